// File: rtl/pwm_fader_pkg.sv
// Shared types and defaults for the PWM fader.
// Define PWM_GAMMA_EN to enable the square-law gamma correction helper.
package pwm_fader_pkg;

  localparam int DUTY_W         = 8;
  localparam int DEFAULT_STEP   = 1;
  localparam int DEFAULT_PERIOD = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

`ifdef PWM_GAMMA_EN
  // Rounds duty^2/256 upwards so that 1 stays visible and 255 stays full-on.
  function automatic logic [DUTY_W-1:0] gamma_correct(input logic [DUTY_W-1:0] d);
    logic [2*DUTY_W-1:0] sq;
    sq = {{DUTY_W{1'b0}}, d} * {{DUTY_W{1'b0}}, d};
    return DUTY_W'((sq + 16'd255) >> DUTY_W);
  endfunction
`endif

endpackage

// File: rtl/pwm_fader_tick_edge.sv
// Rising-edge detector for a divider level that is already synchronous to clk.
module tick_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  output logic edge_o
);

  logic tick_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_i;
  end

  assign edge_o = tick_i & ~tick_q;

endmodule

// File: rtl/pwm_fader.sv
// Glitch-free PWM generator with a frame-paced duty ramp toward a requested target.
// Optional gamma correction of the shadow duty with PWM_GAMMA_EN.
module pwm_fader
  import pwm_fader_pkg::*;
#(
  parameter int STEP   = DEFAULT_STEP,
  parameter int PERIOD = DEFAULT_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_tick,
  input  logic              frame_tick,
  input  logic [DUTY_W-1:0] target,
  input  logic              target_valid,
  output logic              target_ready,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] STEP_W   = DUTY_W'(STEP);

  logic pwm_edge, frame_edge;

  tick_edge u_pwm_edge   (.clk(clk), .rst_n(rst_n), .tick_i(pwm_tick),   .edge_o(pwm_edge));
  tick_edge u_frame_edge (.clk(clk), .rst_n(rst_n), .tick_i(frame_tick), .edge_o(frame_edge));

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] duty_sh_q, duty_sh_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_eff;
  logic              pwm_out_q;
  state_e            state_q, state_d;

`ifdef PWM_GAMMA_EN
  assign duty_eff = gamma_correct(duty_q);
`else
  assign duty_eff = duty_q;
`endif

  // Widened arithmetic so the ramp saturates at the target instead of wrapping.
  logic        [DUTY_W:0]   sum_up;
  logic signed [DUTY_W+1:0] diff_dn;
  logic                     up_done, down_done, accept;

  assign sum_up    = {1'b0, duty_q} + {1'b0, STEP_W};
  assign diff_dn   = $signed({2'b00, duty_q}) - $signed({2'b00, STEP_W});
  assign up_done   = sum_up >= {1'b0, target_q};
  assign down_done = diff_dn <= $signed({2'b00, target_q});
  assign accept    = target_valid & target_ready;

  // The shadow only reloads on the wrapping edge, so a period is never cut short.
  always_comb begin
    cnt_d     = cnt_q;
    duty_sh_d = duty_sh_q;
    if (pwm_edge) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d     = '0;
        duty_sh_d = duty_eff;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = target;
          if (target > duty_q)      state_d = UP;
          else if (target < duty_q) state_d = DOWN;
        end
      end
      UP: begin
        if (frame_edge) begin
          if (up_done) begin
            duty_d  = target_q;
            state_d = IDLE;
          end else begin
            duty_d = sum_up[DUTY_W-1:0];
          end
        end
      end
      DOWN: begin
        if (frame_edge) begin
          if (down_done) begin
            duty_d  = target_q;
            state_d = IDLE;
          end else begin
            duty_d = diff_dn[DUTY_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      duty_q    <= '0;
      duty_sh_q <= '0;
      target_q  <= '0;
      state_q   <= IDLE;
      pwm_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      duty_sh_q <= duty_sh_d;
      target_q  <= target_d;
      state_q   <= state_d;
      pwm_out_q <= (cnt_q < duty_sh_q);
    end
  end

  assign pwm_out      = pwm_out_q;
  assign duty         = duty_q;
  assign busy         = (state_q != IDLE);
  assign target_ready = (state_q == IDLE);

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench: a slow-ramping (STEP=10) and a single-frame (STEP=255) fader
// share clock, reset and ticks; a behavioural model predicts duty and PWM high counts.
module tb_pwm_fader;

  localparam int PERIOD = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_tick = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] target_s = '0, target_f = '0;
  logic       valid_s = 1'b0, valid_f = 1'b0;
  logic       ready_s, ready_f, pwm_s, pwm_f, busy_s, busy_f;
  logic [7:0] duty_s, duty_f;

  int checks = 0;
  int failures = 0;
  int cnt_m = 0;
  int duty_s_m = 0;
  int duty_f_m = 0;

  always #40 clk = ~clk;

  pwm_fader #(.STEP(10), .PERIOD(PERIOD)) u_slow (
    .clk(clk), .rst_n(rst_n), .pwm_tick(pwm_tick), .frame_tick(frame_tick),
    .target(target_s), .target_valid(valid_s), .target_ready(ready_s),
    .pwm_out(pwm_s), .duty(duty_s), .busy(busy_s)
  );

  pwm_fader #(.STEP(255), .PERIOD(PERIOD)) u_fast (
    .clk(clk), .rst_n(rst_n), .pwm_tick(pwm_tick), .frame_tick(frame_tick),
    .target(target_f), .target_valid(valid_f), .target_ready(ready_f),
    .pwm_out(pwm_f), .duty(duty_f), .busy(busy_f)
  );

  // Reference rules: perceived duty and one ramp step toward the target.
  function automatic int eff(input int d);
`ifdef PWM_GAMMA_EN
    return (d * d + 255) / 256;
`else
    return d;
`endif
  endfunction

  function automatic int next_duty(input int d, input int t, input int step);
    if (t > d) return (d + step < t) ? d + step : t;
    if (t < d) return (d - step > t) ? d - step : t;
    return d;
  endfunction

  task automatic pwm_pulse();
    @(negedge clk) pwm_tick = 1'b1;
    @(negedge clk) pwm_tick = 1'b0;
    cnt_m = (cnt_m + 1) % PERIOD;
  endtask

  task automatic frame_pulse();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic both_pulse();
    @(negedge clk) begin pwm_tick = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin pwm_tick = 1'b0; frame_tick = 1'b0; end
    cnt_m = (cnt_m + 1) % PERIOD;
  endtask

  task automatic request(input bit fast, input int tgt);
    @(negedge clk);
    if (fast) begin target_f = 8'(tgt); valid_f = 1'b1; end
    else      begin target_s = 8'(tgt); valid_s = 1'b1; end
    @(negedge clk);
    valid_f = 1'b0;
    valid_s = 1'b0;
  endtask

  // Forces at least one wrap so the shadow holds the current duty.
  task automatic wrap();
    do pwm_pulse(); while (cnt_m != 0);
  endtask

  // Counts high samples over one full period starting at counter value 0.
  task automatic measure_now(input bit fast, output int highs);
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) pwm_pulse();
      @(negedge clk);
      if ((fast ? pwm_f : pwm_s) === 1'b1) highs++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pwm_tick   = ~pwm_tick;
      frame_tick = (i % 3 == 0);
      checks++;
      if (pwm_s !== 1'b0 || duty_s !== 8'd0 || busy_s !== 1'b0 || ready_s !== 1'b1) begin
        failures++;
        $display("FAIL reset_slow: pwm=%b duty=%0d busy=%b ready=%b, want 0 0 0 1",
                 pwm_s, duty_s, busy_s, ready_s);
      end
      checks++;
      if (pwm_f !== 1'b0 || duty_f !== 8'd0 || busy_f !== 1'b0 || ready_f !== 1'b1) begin
        failures++;
        $display("FAIL reset_fast: pwm=%b duty=%0d busy=%b ready=%b, want 0 0 0 1",
                 pwm_f, duty_f, busy_f, ready_f);
      end
    end
    @(negedge clk) begin pwm_tick = 1'b0; frame_tick = 1'b0; end
    @(negedge clk) rst_n = 1'b1;
    cnt_m = 0; duty_s_m = 0; duty_f_m = 0;
  endtask

  task automatic test_pwm_accuracy();
    int list[8];
    int h;
    list = '{64, 0, 255, 128, 1, 0, 0, 0};
    for (int i = 5; i < 8; i++) list[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      request(1'b1, list[i]);
      checks++;
      if (busy_f !== (list[i] != duty_f_m)) begin
        failures++;
        $display("FAIL accept_busy t=%0d: busy=%b want %b", list[i], busy_f, list[i] != duty_f_m);
      end
      frame_pulse();
      duty_f_m = next_duty(duty_f_m, list[i], 255);
      checks++;
      if (int'(duty_f) !== duty_f_m || busy_f !== 1'b0) begin
        failures++;
        $display("FAIL one_frame t=%0d: duty=%0d busy=%b want %0d 0", list[i], duty_f, busy_f, duty_f_m);
      end
      wrap();
      measure_now(1'b1, h);
      checks++;
      if (h !== eff(duty_f_m)) begin
        failures++;
        $display("FAIL pwm_count duty=%0d: high=%0d want %0d", duty_f_m, h, eff(duty_f_m));
      end
    end
  endtask

  task automatic test_ramp_up();
    int exp_d[3];
    exp_d = '{10, 20, 25};
    request(1'b0, 25);
    checks++;
    if (busy_s !== 1'b1 || ready_s !== 1'b0) begin
      failures++;
      $display("FAIL ramp_up_start: busy=%b ready=%b want 1 0", busy_s, ready_s);
    end
    for (int i = 0; i < 3; i++) begin
      frame_pulse();
      checks++;
      if (int'(duty_s) !== exp_d[i] || busy_s !== (i < 2)) begin
        failures++;
        $display("FAIL ramp_up step %0d: duty=%0d busy=%b want %0d %b", i, duty_s, busy_s, exp_d[i], i < 2);
      end
    end
    checks++;
    if (ready_s !== 1'b1) begin
      failures++;
      $display("FAIL ramp_up_ready: ready=%b want 1", ready_s);
    end
    duty_s_m = 25;
  endtask

  task automatic test_ramp_down();
    int exp_d[3];
    exp_d = '{15, 5, 0};
    request(1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      frame_pulse();
      checks++;
      if (int'(duty_s) !== exp_d[i] || busy_s !== (i < 2)) begin
        failures++;
        $display("FAIL ramp_down step %0d: duty=%0d busy=%b want %0d %b", i, duty_s, busy_s, exp_d[i], i < 2);
      end
    end
    frame_pulse();
    checks++;
    if (duty_s !== 8'd0 || ready_s !== 1'b1) begin
      failures++;
      $display("FAIL ramp_down_floor: duty=%0d ready=%b want 0 1", duty_s, ready_s);
    end
    duty_s_m = 0;
  endtask

  task automatic test_reset_mid_ramp();
    request(1'b0, 100);
    frame_pulse();
    frame_pulse();
    checks++;
    if (duty_s !== 8'd20 || busy_s !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: duty=%0d busy=%b want 20 1", duty_s, busy_s);
    end
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if (duty_s !== 8'd0 || busy_s !== 1'b0 || ready_s !== 1'b1 || pwm_s !== 1'b0 ||
        duty_f !== 8'd0 || pwm_f !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: duty_s=%0d busy=%b ready=%b pwm_s=%b duty_f=%0d pwm_f=%b want 0 0 1 0 0 0",
               duty_s, busy_s, ready_s, pwm_s, duty_f, pwm_f);
    end
    @(negedge clk) begin pwm_tick = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin pwm_tick = 1'b0; frame_tick = 1'b0; end
    @(negedge clk) rst_n = 1'b1;
    cnt_m = 0; duty_s_m = 0; duty_f_m = 0;
    request(1'b0, 30);
    for (int i = 1; i <= 3; i++) begin
      frame_pulse();
      checks++;
      if (int'(duty_s) !== 10 * i) begin
        failures++;
        $display("FAIL post_reset_ramp %0d: duty=%0d want %0d", i, duty_s, 10 * i);
      end
    end
    duty_s_m = 30;
  endtask

  task automatic test_busy();
    int frames = 0;
    request(1'b0, 200);
    while (duty_s_m != 200 && frames < 40) begin
      frame_pulse();
      frames++;
      duty_s_m = next_duty(duty_s_m, 200, 10);
      if (frames == 2) request(1'b0, 3);
      checks++;
      if (int'(duty_s) !== duty_s_m || busy_s !== (duty_s_m != 200)) begin
        failures++;
        $display("FAIL busy_ramp frame %0d: duty=%0d busy=%b want %0d %b",
                 frames, duty_s, busy_s, duty_s_m, duty_s_m != 200);
      end
    end
    frame_pulse();
    checks++;
    if (duty_s !== 8'd200 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL busy_final: duty=%0d busy=%b want 200 0", duty_s, busy_s);
    end
  endtask

  task automatic test_random_ramps();
    for (int n = 0; n < 6; n++) begin
      int t;
      int frames;
      t = int'($urandom_range(0, 255));
      frames = 0;
      request(1'b0, t);
      while (duty_s_m != t && frames < 30) begin
        frame_pulse();
        frames++;
        duty_s_m = next_duty(duty_s_m, t, 10);
        checks++;
        if (int'(duty_s) !== duty_s_m || busy_s !== (duty_s_m != t)) begin
          failures++;
          $display("FAIL rand_ramp t=%0d frame %0d: duty=%0d busy=%b want %0d %b",
                   t, frames, duty_s, busy_s, duty_s_m, duty_s_m != t);
        end
      end
    end
  endtask

  task automatic test_back_to_back_edges();
    int old_d, new_d, h;
    old_d = duty_f_m;
    new_d = (old_d + 100) % 256;
    request(1'b1, new_d);
    while (cnt_m != PERIOD - 1) pwm_pulse();
    both_pulse();
    duty_f_m = new_d;
    checks++;
    if (int'(duty_f) !== new_d) begin
      failures++;
      $display("FAIL simul_duty: duty=%0d want %0d", duty_f, new_d);
    end
    measure_now(1'b1, h);
    checks++;
    if (h !== eff(old_d)) begin
      failures++;
      $display("FAIL simul_shadow_old: high=%0d want %0d", h, eff(old_d));
    end
    wrap();
    measure_now(1'b1, h);
    checks++;
    if (h !== eff(new_d)) begin
      failures++;
      $display("FAIL simul_shadow_new: high=%0d want %0d", h, eff(new_d));
    end
  endtask

  initial begin
    test_reset();
    test_pwm_accuracy();
    test_ramp_up();
    test_ramp_down();
    test_reset_mid_ramp();
    test_busy();
    test_random_ramps();
    test_back_to_back_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(80 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 SHALL have parameter STEP, default 1, meaning the duty increment or decrement applied per frame tick during a ramp (legal range 1..255).
REQ-002 SHALL have parameter PERIOD, default 255, meaning PWM counter steps per PWM period.
REQ-003 SHALL have port clk  input  1  system clock, 12.5 MHz; one clock only.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pwm_tick  input  1  clkPwm level from the clock divider; synchronous to clk; only its rising edge is used.
REQ-006 SHALL have port frame_tick  input  1  clk60 level from the clock divider; synchronous to clk; only its rising edge is used.
REQ-007 SHALL have port target  input  8  requested final duty.
REQ-008 SHALL have port target_valid  input  1  target request.
REQ-009 SHALL have port target_ready  output  1  request can be accepted.
REQ-010 SHALL have port pwm_out  output  1  PWM output.
REQ-011 SHALL have port duty  output  8  current logical duty.
REQ-012 SHALL have port busy  output  1  high while ramping.

Function
REQ-013 SHALL detect edges with a one-cycle registered history per tick input: edge = tick & ~tick_q, where tick_q is the tick value from the previous clk cycle.
REQ-014 SHALL keep an 8-bit counter cnt that increments on each pwm_tick edge and wraps from PERIOD-1 to 0.
REQ-015 SHALL drive pwm_out = (cnt < duty_sh) as a registered output; duty 0 SHALL hold pwm_out low and duty 255 SHALL hold it high.
REQ-016 SHALL load the shadow duty_sh from duty_eff only on the pwm_tick edge that wraps cnt to 0, so no period is ever truncated or glitched.
REQ-017 SHALL implement FSM states IDLE, UP and DOWN.
REQ-018 SHALL assert target_ready only in IDLE and SHALL accept a request when target_valid & target_ready.
REQ-019 On accept, the FSM SHALL go to UP if target > duty, to DOWN if target < duty, and stay in IDLE if they are equal; the target SHALL be latched.
REQ-020 On each frame_tick edge, UP SHALL set duty = min(duty+STEP, target) using a 9-bit sum, and DOWN SHALL set duty = max(duty-STEP, target) using a signed compare; reaching target SHALL return the FSM to IDLE on the same edge.
REQ-021 SHALL set busy = (state != IDLE).
REQ-022 Simultaneous pwm_tick and frame_tick edges SHALL both take effect in the same cycle, with the PWM shadow load using the pre-update duty.
REQ-023 SHALL ignore target_valid while busy; no request is queued.

Reset
REQ-024 With rst_n low, the block SHALL force cnt=0, duty=0, duty_sh=0, pwm_out=0, state=IDLE, target_ready=1, busy=0, tick_q=0 and latched target=0, asynchronously.
REQ-025 Reset asserted mid-ramp SHALL abandon the ramp, and after release the block SHALL resume from the reset state with no residual edge detection.

Configuration
REQ-026 With PWM_GAMMA_EN defined, the block SHALL use duty_eff = (duty*duty + 255) >> 8, a 16-bit product, giving 0->0, 1->1, 128->64 and 255->255.
REQ-027 Without PWM_GAMMA_EN, the block SHALL use duty_eff = duty, with no multiplier instantiated.

Structure
REQ-028 Package pwm_fader_pkg SHALL hold the FSM state typedef, the default STEP, the default PERIOD and the duty width of 8.
REQ-029 The block SHALL contain one sub-module, tick_edge, a registered rising-edge detector instantiated twice.

Verification
REQ-030 Reset check: hold rst_n low with ticks toggling -> pwm_out=0, duty=0, busy=0, target_ready=1.
REQ-031 PWM accuracy: STEP=255, target=64, one frame edge -> duty=64, and after the next wrap pwm_out is high for exactly 64 of 255 pwm_tick edges per period; duty 0 -> always low, duty 255 -> always high.
REQ-032 Ramp up: STEP=10, duty 0, target 25 -> duty 10, 20, 25 on successive frame edges, then IDLE and ready=1.
REQ-033 Ramp down: from duty 25, target 0, STEP=10 -> duty 15, 5, 0 with no underflow.
REQ-034 Busy handling: target_valid during a ramp -> ignored, and the final duty equals the original target.
REQ-035 Reset mid-ramp: rst_n pulsed at duty 20 -> outputs take reset values immediately. With PWM_GAMMA_EN: duty 128 -> high count 64 per period.
